bin_to_bcd_seq: RTL and testbench

//   Sequential binary-to-BCD converter (shift-and-add-3). Takes an unsigned binary

---
 rtl/bin_to_bcd_seq.sv | 118 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, IN_W cycles per conversion.
// Optional leading-zero blanking mask on port blank when LZB_EN is defined.
module bin_to_bcd_seq #(
   parameter int IN_W   = 8,
   parameter int DIGITS = 3
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  start,
   input  logic [IN_W-1:0]       bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow
`ifdef LZB_EN
   ,
   output logic [DIGITS-1:0]     blank
`endif
);

   // Scratch holds enough digits for any IN_W-bit value, even if DIGITS is smaller.
   localparam int SCR = (DIGITS > (IN_W + 2) / 3) ? DIGITS : (IN_W + 2) / 3;
   localparam int CW  = $clog2(IN_W + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

   state_t              state, state_nxt;
   logic [IN_W-1:0]     sh;
   logic [4*SCR-1:0]    scr, scr_adj, scr_nxt, scr_hi;
   logic [CW-1:0]       cnt;
   logic                load, last;
   logic                ovf_nxt;
   logic [4*DIGITS-1:0] bcd_nxt;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt == CW'(1)) begin
               last      = 1'b1;
               state_nxt = FINISH;
            end
         end
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == SHIFT);
   assign done = (state == FINISH);

   // Adjust every digit, then shift the next binary bit into the ones digit.
   always_comb begin
      scr_adj = scr;
      for (int i = 0; i < SCR; i++)
         if (scr[4*i +: 4] >= 4'd5) scr_adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
      scr_nxt = (scr_adj << 1) | {{(4*SCR-1){1'b0}}, sh[IN_W-1]};
      scr_hi  = scr_nxt >> (4 * DIGITS);
      ovf_nxt = |scr_hi;
      bcd_nxt = ovf_nxt ? {DIGITS{4'h9}} : scr_nxt[4*DIGITS-1:0];
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sh       <= '0;
         scr      <= '0;
         cnt      <= '0;
         bcd      <= '0;
         overflow <= 1'b0;
      end else if (load) begin
         sh  <= bin;
         scr <= '0;
         cnt <= CW'(IN_W);
      end else if (state == SHIFT) begin
         sh  <= sh << 1;
         scr <= scr_nxt;
         cnt <= cnt - 1'b1;
         if (last) begin
            bcd      <= bcd_nxt;
            overflow <= ovf_nxt;
         end
      end
   end

`ifdef LZB_EN
   logic [DIGITS-1:0] blank_nxt;
   logic              zero_hi;

   // Walk down from the top digit; blank while everything above is still zero.
   always_comb begin
      blank_nxt = '0;
      zero_hi   = ~ovf_nxt;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_hi      = zero_hi & (bcd_nxt[4*i +: 4] == 4'd0);
         blank_nxt[i] = zero_hi;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)                       blank <= '0;
      else if (state == SHIFT && last) blank <= blank_nxt;
   end
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: 3-digit and 2-digit instances driven in parallel.
// Blank checks are active when LZB_EN is defined.
module tb_bin_to_bcd_seq;
   localparam int IN_W = 8;

   logic        Clk = 1'b0;
   logic        Reset, start;
   logic [7:0]  bin;
   logic        busy3, done3, ovf3, busy2, done2, ovf2;
   logic [11:0] bcd3;
   logic [7:0]  bcd2;
`ifdef LZB_EN
   logic [2:0]  blank3;
   logic [1:0]  blank2;
`endif

   int checks = 0;
   int errors = 0;

   logic [11:0] c_bcd3;
   logic [7:0]  c_bcd2;
   logic        c_ovf3, c_ovf2;
   logic [2:0]  c_bl3;
   logic [1:0]  c_bl2;

   bin_to_bcd_seq #(.IN_W(IN_W), .DIGITS(3)) dut3 (
      .Clk(Clk), .Reset(Reset), .start(start), .bin(bin),
      .busy(busy3), .done(done3), .bcd(bcd3), .overflow(ovf3)
`ifdef LZB_EN
      , .blank(blank3)
`endif
   );

   bin_to_bcd_seq #(.IN_W(IN_W), .DIGITS(2)) dut2 (
      .Clk(Clk), .Reset(Reset), .start(start), .bin(bin),
      .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2)
`ifdef LZB_EN
      , .blank(blank2)
`endif
   );

   always #5 Clk = ~Clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int pow10(input int n);
      int p = 1;
      for (int i = 0; i < n; i++) p *= 10;
      return p;
   endfunction

   // Decimal digits by division; saturate to all nines when out of range.
   function automatic logic [19:0] ref_bcd(input int v, input int nd);
      logic [19:0] r = '0;
      for (int i = 0; i < nd; i++)
         r[4*i +: 4] = (v >= pow10(nd)) ? 4'h9 : 4'((v / pow10(i)) % 10);
      return r;
   endfunction

   function automatic logic [4:0] ref_blank(input int v, input int nd);
      logic [4:0] b = '0;
      if (v < pow10(nd))
         for (int i = 1; i < nd; i++) b[i] = ((v / pow10(i)) == 0);
      return b;
   endfunction

   task automatic capture;
      c_bcd3 = bcd3; c_ovf3 = ovf3; c_bcd2 = bcd2; c_ovf2 = ovf2;
`ifdef LZB_EN
      c_bl3 = blank3; c_bl2 = blank2;
`else
      c_bl3 = '0; c_bl2 = '0;
`endif
   endtask

   // One conversion: checks latency, busy span and single-cycle done, then captures.
   task automatic run(input logic [7:0] v);
      int lat, bcnt;
      @(negedge Clk); start = 1'b1; bin = v;
      @(posedge Clk); #1; start = 1'b0; bin = 8'($urandom);
      lat = -1; bcnt = 0;
      for (int c = 0; c < IN_W + 4; c++) begin
         if (done3) begin lat = c; break; end
         if (busy3) bcnt++;
         @(posedge Clk); #1;
      end
      chk("latency", lat, IN_W);
      chk("busy_cycles", bcnt, IN_W);
      chk("done2_sync", done2, 1);
      chk("busy_at_done", busy3, 0);
      capture();
      @(posedge Clk); #1;
      chk("done_single", done3, 0);
   endtask

   task automatic check_model(input int v);
      logic [19:0] e3, e2;
      logic [4:0]  b3, b2;
      e3 = ref_bcd(v, 3); e2 = ref_bcd(v, 2);
      b3 = ref_blank(v, 3); b2 = ref_blank(v, 2);
      chk("bcd3", c_bcd3, e3[11:0]);
      chk("ovf3", c_ovf3, v > 999);
      chk("bcd2", c_bcd2, e2[7:0]);
      chk("ovf2", c_ovf2, v > 99);
`ifdef LZB_EN
      chk("blank3", c_bl3, b3[2:0]);
      chk("blank2", c_bl2, b2[1:0]);
`endif
   endtask

   typedef struct {
      logic [7:0]  v;
      logic [11:0] b3;
      logic [7:0]  b2;
      logic        o2;
      logic [2:0]  bl3;
   } vec_t;

   vec_t tbl[9];

   initial begin
      int nd, t1, t2, e;
      logic [11:0] held;

      tbl[0] = '{8'd0,   12'h000, 8'h00, 1'b0, 3'b110};
      tbl[1] = '{8'd255, 12'h255, 8'h99, 1'b1, 3'b000};
      tbl[2] = '{8'd99,  12'h099, 8'h99, 1'b0, 3'b100};
      tbl[3] = '{8'd100, 12'h100, 8'h99, 1'b1, 3'b000};
      tbl[4] = '{8'd200, 12'h200, 8'h99, 1'b1, 3'b000};
      tbl[5] = '{8'd57,  12'h057, 8'h57, 1'b0, 3'b100};
      tbl[6] = '{8'd7,   12'h007, 8'h07, 1'b0, 3'b110};
      tbl[7] = '{8'd40,  12'h040, 8'h40, 1'b0, 3'b100};
      tbl[8] = '{8'd105, 12'h105, 8'h99, 1'b1, 3'b000};

      Reset = 1'b1; start = 1'b0; bin = '0;
      repeat (2) @(posedge Clk);
      #1;
      chk("rst_busy", busy3, 0);
      chk("rst_done", done3, 0);
      chk("rst_bcd3", bcd3, 0);
      chk("rst_ovf3", ovf3, 0);
      chk("rst_bcd2", bcd2, 0);
`ifdef LZB_EN
      chk("rst_blank3", blank3, 0);
`endif
      @(negedge Clk); Reset = 1'b0;

      foreach (tbl[i]) begin
         run(tbl[i].v);
         chk("tbl_bcd3", c_bcd3, tbl[i].b3);
         chk("tbl_ovf3", c_ovf3, 0);
         chk("tbl_bcd2", c_bcd2, tbl[i].b2);
         chk("tbl_ovf2", c_ovf2, tbl[i].o2);
`ifdef LZB_EN
         chk("tbl_blank3", c_bl3, tbl[i].bl3);
`endif
         // Outputs must hold between done pulses.
         repeat (3) @(posedge Clk);
         #1;
         chk("hold_bcd3", bcd3, tbl[i].b3);
      end

      // Second start while busy must be ignored.
      @(negedge Clk); start = 1'b1; bin = 8'd42;
      @(posedge Clk); #1; start = 1'b0;
      repeat (2) @(posedge Clk);
      @(negedge Clk); start = 1'b1; bin = 8'd7;
      @(posedge Clk); #1; start = 1'b0;
      nd = 0; held = '0;
      for (int c = 0; c < 20; c++) begin
         if (done3) begin nd++; held = bcd3; end
         @(posedge Clk); #1;
      end
      chk("ignore_ndone", nd, 1);
      chk("ignore_bcd", held, 12'h042);

      // Reset mid-conversion aborts with no done.
      @(negedge Clk); start = 1'b1; bin = 8'd200;
      @(posedge Clk); #1; start = 1'b0;
      repeat (3) @(posedge Clk);
      @(negedge Clk); Reset = 1'b1;
      #1;
      chk("abort_busy", busy3, 0);
      chk("abort_bcd3", bcd3, 0);
      chk("abort_bcd2", bcd2, 0);
      chk("abort_ovf2", ovf2, 0);
      @(negedge Clk); Reset = 1'b0;
      nd = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge Clk); #1;
         if (done3) nd++;
      end
      chk("abort_ndone", nd, 0);
      run(8'd13);
      chk("after_abort_bcd", c_bcd3, 12'h013);

      // start held high: back-to-back conversions every IN_W+2 cycles.
      @(negedge Clk); start = 1'b1; bin = 8'd5;
      t1 = -1; t2 = -1;
      for (e = 0; e < 40 && t2 < 0; e++) begin
         @(posedge Clk); #1;
         if (done3) begin
            if (t1 < 0) t1 = e;
            else        t2 = e;
         end
      end
      start = 1'b0;
      chk("b2b_period", t2 - t1, IN_W + 2);
      chk("b2b_bcd", bcd3, 12'h005);
      repeat (IN_W + 4) @(posedge Clk);

      for (int v = 0; v < 256; v++) begin
         run(8'(v));
         check_model(v);
      end

      for (int n = 0; n < 40; n++) begin
         int v;
         v = int'($urandom_range(0, 255));
         run(8'(v));
         check_model(v);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
